// File: rtl/pipelined_adder.sv
// N-bit adder whose carry chain is cut into STAGES registered segments.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: N must be a multiple of STAGES");
  end

  logic         adv;
  logic [W:0]   part;

  logic         v_q   [STAGES];
  logic         v_d   [STAGES];
  logic         c_q   [STAGES];
  logic         c_d   [STAGES];
  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] a_d   [STAGES];
  logic [N-1:0] b_q   [STAGES];
  logic [N-1:0] b_d   [STAGES];
  logic [N-1:0] s_q   [STAGES];
  logic [N-1:0] s_d   [STAGES];

  logic         v_src [STAGES];
  logic         c_src [STAGES];
  logic [N-1:0] a_src [STAGES];
  logic [N-1:0] b_src [STAGES];
  logic [N-1:0] s_src [STAGES];

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;
`endif

  always_comb begin
    adv      = !v_q[L] || out_ready;
    part     = '0;
    v_src[0] = in_valid;
    c_src[0] = cin;
    a_src[0] = a;
    b_src[0] = b;
    s_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      c_src[k] = c_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
    end
    // each stage resolves one W-bit slice with the carry of the stage before
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = v_q[k];
      c_d[k] = c_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      if (adv) begin
        part = {1'b0, a_src[k][k*W +: W]}
             + {1'b0, b_src[k][k*W +: W]}
             + {{W{1'b0}}, c_src[k]};
        v_d[k]           = v_src[k];
        c_d[k]           = part[W];
        a_d[k]           = a_src[k];
        b_d[k]           = b_src[k];
        s_d[k]           = s_src[k];
        s_d[k][k*W +: W] = part[W-1:0];
      end
    end
`ifdef PIPELINED_ADDER_OVF_EN
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = (a_src[L][N-1] == b_src[L][N-1])
           && (s_d[L][N-1] != a_src[L][N-1]);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[L];
  assign s         = s_q[L];
  assign cout      = c_q[L];
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: N=8 with STAGES 2, 1, 4 and 8 side by side.
// Checks ovf as well when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [4];
  logic       ordy [4];
  logic       ci   [4];
  logic       irdy [4];
  logic       ov   [4];
  logic       co   [4];
  logic [7:0] av   [4];
  logic [7:0] bv   [4];
  logic [7:0] sv   [4];
`ifdef PIPELINED_ADDER_OVF_EN
  logic       of   [4];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    pipelined_adder #(.N(8), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (irdy[g]),
      .a         (av[g]),
      .b         (bv[g]),
      .cin       (ci[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .s         (sv[g]),
      .cout      (co[g])
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf       (of[g])
`endif
    );
  end

  typedef struct {
    logic [8:0] sum;
    logic       ovf;
    int         stamp;
  } exp_t;

  exp_t q[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   adv_cnt = 0;
  int   n_pop   = 0;
  int   n_push  = 0;
  logic last_fire;
  logic last_irdy;

  function automatic int st_of(input int j);
    case (j)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: score handshakes at the sample point, then cross the edge
  task automatic tick(input int j);
    exp_t e;
    #1;
    last_irdy = irdy[j];
    last_fire = iv[j] && irdy[j];
    if (ov[j] && ordy[j]) begin
      chk("out_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_pop++;
        chk("s", sv[j], e.sum[7:0]);
        chk("cout", co[j], e.sum[8]);
        chk("latency", adv_cnt - e.stamp, st_of(j) - 1);
`ifdef PIPELINED_ADDER_OVF_EN
        chk("ovf", of[j], e.ovf);
`endif
      end
    end
    if (last_fire) begin
      e.sum   = {1'b0, av[j]} + {1'b0, bv[j]} + {8'd0, ci[j]};
      e.ovf   = (av[j][7] == bv[j][7]) && (e.sum[7] != av[j][7]);
      e.stamp = adv_cnt + 1;
      q.push_back(e);
      n_push++;
    end
    if (irdy[j]) adv_cnt++;
    @(negedge clk);
  endtask

  task automatic send(input int j, input logic [7:0] x,
                      input logic [7:0] y, input logic c);
    int n;
    av[j] = x;
    bv[j] = y;
    ci[j] = c;
    iv[j] = 1'b1;
    n = 0;
    last_fire = 1'b0;
    while (!last_fire && n < 50) begin
      tick(j);
      n++;
    end
    iv[j] = 1'b0;
    chk("send_accepted", last_fire, 1);
  endtask

  task automatic drain(input int j, input int limit);
    int n;
    iv[j]   = 1'b0;
    ordy[j] = 1'b1;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      tick(j);
      n++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      iv[j]   = 1'b0;
      ordy[j] = 1'b1;
      ci[j]   = 1'b0;
      av[j]   = '0;
      bv[j]   = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      chk("rst_valid", ov[j], 0);
      chk("rst_s", sv[j], 0);
      chk("rst_cout", co[j], 0);
`ifdef PIPELINED_ADDER_OVF_EN
      chk("rst_ovf", of[j], 0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("in_ready_after_rst", irdy[0], 1);
    @(negedge clk);

    // single add 2+3
    send(0, 8'd2, 8'd3, 1'b0);
    drain(0, 20);
    chk("valid_drop", ov[0], 0);

    // carry out and overflow corners
    send(0, 8'h80, 8'h7F, 1'b1);
    send(0, 8'h7F, 8'h01, 1'b0);
    drain(0, 20);

    // streaming at full rate
    p0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      av[0] = 8'(i);
      bv[0] = 8'(2 * i);
      ci[0] = i[0];
      iv[0] = 1'b1;
      tick(0);
      chk("stream_in_ready", last_irdy, 1);
    end
    iv[0] = 1'b0;
    drain(0, 20);
    chk("stream_count", n_pop - p0, 16);

    // backpressure: stall with a result waiting at the output
    p0 = n_pop;
    ordy[0] = 1'b0;
    send(0, 8'h11, 8'h22, 1'b0);
    send(0, 8'hF0, 8'h20, 1'b1);
    av[0] = 8'h33;
    bv[0] = 8'h44;
    ci[0] = 1'b1;
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(0);
      chk("stall_in_ready", last_irdy, 0);
      chk("stall_valid", ov[0], 1);
      chk("stall_s", sv[0], 8'h33);
      chk("stall_cout", co[0], 0);
    end
    ordy[0] = 1'b1;
    send(0, 8'h33, 8'h44, 1'b1);
    send(0, 8'hFF, 8'hFF, 1'b1);
    drain(0, 20);
    chk("stall_count", n_pop - p0, 4);

    // reset while two results are in flight
    ordy[0] = 1'b0;
    send(0, 8'h55, 8'h66, 1'b0);
    send(0, 8'h77, 8'h88, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_s", sv[0], 0);
    chk("mid_rst_cout", co[0], 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(0);
      chk("no_stale_result", ov[0], 0);
    end

    // random traffic on every configuration
    for (int j = 0; j < 4; j++) begin
      p0 = n_pop;
      n_push = 0;
      for (int i = 0; i < 1000; i++) begin
        av[j]   = 8'($urandom);
        bv[j]   = 8'($urandom);
        ci[j]   = 1'($urandom);
        iv[j]   = ($urandom_range(0, 3) != 0);
        ordy[j] = ($urandom_range(0, 9) < 7);
        tick(j);
      end
      drain(j, 50);
      chk("sweep_count", n_pop - p0, n_push);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised N-bit adder with carry-in and carry-out. The carry chain is split into STAGES equal segments with a register between segments, so throughput is one add per clock at a higher clock rate.
- Streams operands through a valid/ready handshake on input and output.
- Sits in datapaths where the single-cycle ripple-carry adder limits clock frequency.

Parameters:
- N, 8, operand/result width in bits; must be a multiple of STAGES (elaboration-time check, $error otherwise).
- STAGES, 2, number of pipeline segments (1..N); segment width W = N/STAGES; latency = STAGES cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  s/cout hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- s  output  N  sum bits, a+b+cin mod 2^N.
- cout  output  1  carry out of bit N-1.
- ovf  output  1  signed overflow; present only with PIPELINED_ADDER_OVF_EN.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0; out_valid = 0; s = 0; cout = 0; ovf = 0; all data registers = 0. in_ready = 1 one cycle after release.
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Transfer in = in_valid && in_ready.
  - Transfer out = out_valid && out_ready.
- Stage k (0..STAGES-1), on adv:
  - Adds bits [k*W+W-1 : k*W] of a and b with carry from the stage k-1 register (cin for k=0).
  - Registers the W-bit partial sum and carry.
  - Forwards the still-unused higher operand slices.
  - Forwards the already-computed lower sum slices.
  - Valid bit shifts with the data; a non-accepted cycle loads valid=0 (bubble).
- When adv=0 every stage register holds, including bubbles; bubbles are not collapsed.
- Latency: a result accepted at edge t appears with out_valid=1 after edge t+STAGES-1 (STAGES cycles). It is visible from that edge when out_ready was held high.
- Throughput: one result per cycle while out_ready=1.
- s/cout/ovf are stable while out_valid=1 && out_ready=0.
- STAGES=1: single register after a full-width add; latency 1.
- STAGES=N: W=1, pure bit-level pipeline.
- Wrap-around: s is the sum mod 2^N; cout is bit N of the (N+1)-bit sum. No saturation.
- Simultaneous in and out transfer in one cycle: both happen and the pipeline advances one slot.
- Reset mid-operation: all in-flight results are discarded, and no result from before the reset ever appears at the output.
- Data registers need no reset for function; they are reset anyway for deterministic waveforms.

Optional Feature:
- Macro PIPELINED_ADDER_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf = (a[N-1]==b[N-1]) && (s[N-1]!=a[N-1]), the signed overflow flag.
  - Sign bits of a and b are carried down the pipeline to the last stage; ovf is aligned with s.
  - ovf resets to 0 and holds under stall like s.
- Undefined: no ovf port, no sign-bit registers; all other behaviour identical.

Test Plan:
- N=8, STAGES=2; reset, then a=2 b=3 cin=0 in one cycle, out_ready=1 -> out_valid after 2 cycles, s=8'h05, cout=0, then out_valid=0.
- a=8'h80 b=8'h7F cin=1 -> s=8'h00, cout=1. With OVF_EN, ovf=0. Then a=8'h7F b=8'h01 cin=0 -> s=8'h80, cout=0, ovf=1.
- Streaming:
  - Input a=i, b=2*i, cin=i[0] for i=0..15 on consecutive cycles, out_ready=1.
  - Required: 16 consecutive results, in order, matching a golden model.
  - Required: in_ready=1 throughout.
- Backpressure:
  - Stream 4 operands, hold out_ready=0 for 5 cycles after the first result.
  - Required: s/cout held constant and in_ready=0 while stalled.
  - Required: after release, all 4 results appear in order with none lost or duplicated.
- Reset mid-operation: issue 2 transactions, assert rst for 1 cycle before either completes -> out_valid=0, s=0, cout=0 immediately; neither result ever appears.
- Parameter sweep: STAGES=1, 4, 8 with N=8; 1000 random operands with random out_ready -> latency = STAGES; all results match the golden model.
